// File: rtl/rho_rotate_ctrl_pkg.sv
// Shared encoder definitions for the rho (lane-rotate) step: lane geometry,
// sequencer state encoding and the Keccak rho offset table.
package rho_rotate_ctrl_pkg;

    localparam int NUM_LANES     = 25;
    localparam int LANE_IDX_W    = 5;
    localparam int LANE_BITS_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_DONE
    } rho_state_e;

    // Indexed by lane = x + 5*y
    localparam int RHO_OFFSETS [NUM_LANES] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

endpackage

// File: rtl/rho_offset_rom.sv
// Combinational rho offset lookup, reduced mod LANE_BITS.
module rho_offset_rom
    import rho_rotate_ctrl_pkg::*;
#(
    parameter int LANE_BITS = LANE_BITS_DEF,
    parameter int BIT_W     = $clog2(LANE_BITS)
) (
    input  logic [LANE_IDX_W-1:0] lane,
    output logic [BIT_W-1:0]      offset
);

    // Out-of-range lanes never occur in normal sequencing; return 0 for them.
    always_comb begin
        offset = '0;
        if (int'(lane) < NUM_LANES)
            offset = BIT_W'(RHO_OFFSETS[lane] % LANE_BITS);
    end

endmodule

// File: rtl/rho_rotate_ctrl.sv
// Rho step sequencer: walks every lane and issues one bit transfer per cycle
// from src_bit to (src_bit + offset[lane]) mod LANE_BITS.
module rho_rotate_ctrl
    import rho_rotate_ctrl_pkg::*;
#(
    parameter int LANE_BITS = LANE_BITS_DEF,
    parameter int BIT_W     = $clog2(LANE_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic                  xfer_en,
    output logic [LANE_IDX_W-1:0] lane_idx,
    output logic [BIT_W-1:0]      src_bit,
    output logic [BIT_W-1:0]      dst_bit
);

    localparam logic [BIT_W-1:0]      SRC_LAST  = BIT_W'(LANE_BITS - 1);
    localparam logic [LANE_IDX_W-1:0] LANE_LAST = LANE_IDX_W'(NUM_LANES - 1);

    rho_state_e            state_q, state_d;
    logic [LANE_IDX_W-1:0] lane_q;
    logic [BIT_W-1:0]      src_q, dst_q, offset;
    logic                  lane_end;

    rho_offset_rom #(.LANE_BITS(LANE_BITS), .BIT_W(BIT_W)) u_rom (
        .lane   (lane_q),
        .offset (offset)
    );

    assign lane_end = (state_q == ST_XFER) && !stall && (src_q == SRC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        xfer_en = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                busy    = 1'b1;
                state_d = ST_XFER;
            end
            ST_XFER: begin
                busy    = 1'b1;
                xfer_en = !stall;
                if (lane_end) state_d = (lane_q == LANE_LAST) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters advance only on a committed transfer; the final transfer of
    // the pass clears them so DONE/IDLE present an all-zero position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
            src_q  <= '0;
            dst_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) lane_q <= '0;
                ST_LOAD: begin
                    src_q <= '0;
                    dst_q <= offset;
                end
                ST_XFER: if (!stall) begin
                    if (lane_end && lane_q == LANE_LAST) begin
                        lane_q <= '0;
                        src_q  <= '0;
                        dst_q  <= '0;
                    end else begin
                        src_q <= src_q + 1'b1;
                        dst_q <= dst_q + 1'b1;
                        if (lane_end) lane_q <= lane_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    lane_q <= '0;
                    src_q  <= '0;
                    dst_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign lane_idx = lane_q;
    assign src_bit  = src_q;
    assign dst_bit  = dst_q;

endmodule

// File: tb/tb_rho_rotate_ctrl.sv
// Directed bench for rho_rotate_ctrl at default geometry (25 lanes x 64 bits).
module tb_rho_rotate_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stall;
    logic       busy, done, xfer_en;
    logic [4:0] lane_idx;
    logic [5:0] src_bit, dst_bit;

    int n_tests = 0;
    int n_fail  = 0;
    int xfer_total = 0;

    int OFF [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                     41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
    int L2DST [3] = '{62, 63, 0};

    rho_rotate_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .xfer_en  (xfer_en),
        .lane_idx (lane_idx),
        .src_bit  (src_bit),
        .dst_bit  (dst_bit)
    );

    always #5 clk = ~clk;

    // Transfers actually committed at a clock edge
    always @(posedge clk) if (xfer_en === 1'b1) xfer_total++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: clean pass, 1: 5-cycle stall at (7,10), 2: stray starts,
    // 3: reset at (12,30)
    task automatic run_pass(input int mode, input int exp_done_cyc);
        int c, dones, done_cyc, inv_bad, l0_bad, idle_bad, frz_bad;
        int stall_left, tail, base, post_bad;
        bit gap_next, done_next, resume_next, resumed, seen_first, stalled;
        logic       s_x, s_busy, s_done;
        logic [4:0] s_lane;
        logic [5:0] s_src, s_dst;
        {dones, done_cyc, inv_bad, l0_bad, idle_bad, frz_bad} = '0;
        {stall_left, tail, post_bad} = '0;
        {gap_next, done_next, resume_next, resumed, seen_first, stalled} = '0;
        base = xfer_total;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        c = 1;
        while (c < 2200 && !(dones > 0 && tail == 0)) begin
            s_x = xfer_en; s_busy = busy; s_done = done;
            s_lane = lane_idx; s_src = src_bit; s_dst = dst_bit;
            if (gap_next) begin
                chk("gap_xfer_en", s_x, 0);
                chk("gap_lane", s_lane, 3);
                gap_next = 0;
            end
            if (done_next) begin
                chk("done_after_lane24", s_done, 1);
                done_next = 0;
            end
            if (resume_next) begin
                chk("resume_xfer_en", s_x, 1);
                chk("resume_src", s_src, 11);
                chk("resume_dst", s_dst, 17);
                resume_next = 0; resumed = 1;
            end
            if (stall_left > 0) begin
                if (s_x !== 1'b0 || s_lane !== 5'd7 || s_src !== 6'd10 || s_dst !== 6'd16)
                    frz_bad++;
                stall_left--;
                if (stall_left == 0) begin stall = 1'b0; resume_next = 1; end
            end
            if (s_x === 1'b1) begin
                if (s_lane > 5'd24 || s_dst !== 6'((int'(s_src) + OFF[s_lane]) % 64)) inv_bad++;
                if (!seen_first) begin
                    seen_first = 1;
                    chk("first_lane", s_lane, 0);
                    chk("first_src", s_src, 0);
                    chk("first_dst", s_dst, 0);
                end
                if (s_lane == 5'd0 && s_dst !== s_src) l0_bad++;
                if (s_lane == 5'd2 && s_src < 6'd3) chk("lane2_head_dst", s_dst, L2DST[s_src]);
                if (s_lane == 5'd2 && s_src == 6'd63) begin
                    chk("lane2_last_dst", s_dst, 61); gap_next = 1;
                end
                if (s_lane == 5'd24 && s_src == 6'd0) chk("lane24_first_dst", s_dst, 14);
                if (s_lane == 5'd24 && s_src == 6'd63) begin
                    chk("lane24_last_dst", s_dst, 13); done_next = 1;
                end
                if (mode == 1 && !stalled && s_lane == 5'd7 && s_src == 6'd10) begin
                    chk("prestall_dst", s_dst, 16);
                    stall = 1'b1; stall_left = 5; stalled = 1;
                    #1 chk("stall_blocks_xfer", xfer_en, 0);
                end
                if (mode == 3 && s_lane == 5'd12 && s_src == 6'd30) begin
                    rst = 1'b1;
                    #1;
                    chk("arst_busy", busy, 0);
                    chk("arst_done", done, 0);
                    chk("arst_xfer_en", xfer_en, 0);
                    chk("arst_lane", lane_idx, 0);
                    chk("arst_src", src_bit, 0);
                    chk("arst_dst", dst_bit, 0);
                    @(negedge clk); rst = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        if (done !== 1'b0 || busy !== 1'b0 || xfer_en !== 1'b0) post_bad++;
                    end
                    chk("arst_quiet_after", post_bad, 0);
                    return;
                end
            end
            if (mode == 2 && c == 100) start = 1'b1;
            if (mode == 2 && c == 101) start = 1'b0;
            if (s_done === 1'b1) begin
                dones++;
                if (done_cyc == 0) done_cyc = c;
                tail = (mode == 2) ? 20 : 3;
                if (mode == 2) start = 1'b1;
            end else if (tail > 0) begin
                start = 1'b0;
                if (s_busy !== 1'b0 || s_x !== 1'b0) idle_bad++;
                tail--;
            end
            @(negedge clk);
            c++;
        end
        chk("done_cycle", done_cyc, exp_done_cyc);
        chk("done_count", dones, 1);
        chk("xfer_count", xfer_total - base, 1600);
        chk("invariant_bad", inv_bad, 0);
        chk("lane0_identity_bad", l0_bad, 0);
        chk("idle_after_done_bad", idle_bad, 0);
        if (mode == 1) begin
            chk("stall_frozen_bad", frz_bad, 0);
            chk("stall_resumed", resumed, 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_xfer_en", xfer_en, 0);
        chk("rst_lane", lane_idx, 0);
        chk("rst_src", src_bit, 0);
        chk("rst_dst", dst_bit, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        run_pass(0, 1626);
        run_pass(1, 1631);
        run_pass(2, 1626);
        run_pass(3, 0);
        run_pass(0, 1626);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rho_rotate_ctrl.md
Name: rho_rotate_ctrl

Overview:
Sequencer for the encoder's rho (lane-rotate) step. It walks all lanes of the state; for each lane it issues one bit-transfer per cycle, from source bit index b to destination bit index (b + offset[lane]) mod LANE_BITS. It drives the address and enable lines of the state buffer and sits between the round controller (start/done handshake) and the rotate datapath.

Parameters:
NUM_LANES, 25, number of lanes per state (fixed lane-index width 5).
LANE_BITS, 64, bits per lane; power of two, 8..64. Offsets are applied mod LANE_BITS.
BIT_W, $clog2(LANE_BITS), width of bit indices (6 at default).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
start  in  1  request one full rotate pass; sampled only in IDLE
stall  in  1  datapath back-pressure; freezes transfer progress
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse when the pass completes
xfer_en  out  1  move bit src_bit -> dst_bit of lane lane_idx this cycle
lane_idx  out  5  current lane, 0..NUM_LANES-1
src_bit  out  BIT_W  source bit index
dst_bit  out  BIT_W  destination bit index

Behaviour:
- Reset: state IDLE; busy=0, done=0, xfer_en=0, lane_idx=0, src_bit=0, dst_bit=0. Reset mid-pass aborts immediately; no done pulse.
- Counters (all registered):
  - lane counter mod NUM_LANES.
  - src counter mod LANE_BITS, counting up from 0.
  - dst counter mod LANE_BITS, loadable; wraps LANE_BITS-1 -> 0.
- Offset table: standard Keccak rho offsets, indexed by lane = x+5y:
  - lanes 0..4: 0,1,62,28,27
  - lanes 5..9: 36,44,6,55,20
  - lanes 10..14: 3,10,43,25,39
  - lanes 15..19: 41,45,15,21,8
  - lanes 20..24: 18,2,61,56,14
  - Each value is taken mod LANE_BITS.
- FSM states: IDLE, LOAD, XFER, DONE.
  - IDLE: start=1 -> LOAD; lane=0. start=0 -> stay.
  - LOAD (1 cycle): src<=0, dst<=offset[lane]; -> XFER. xfer_en=0.
  - XFER: xfer_en = !stall.
    - If !stall, src and dst advance by 1 at the edge.
    - If stall, all counters hold and the state holds.
    - When !stall and src==LANE_BITS-1: if lane==NUM_LANES-1 -> DONE; else lane+1 and -> LOAD.
  - DONE (1 cycle): done=1, busy=0; -> IDLE. lane, src and dst reset to 0.
- busy=1 in LOAD and XFER only.
- start while busy or in DONE is ignored; it is not queued.
- stall outside XFER has no effect.
- Outputs lane_idx, src_bit and dst_bit are direct register outputs, valid whenever xfer_en=1.
- Latency with no stall: start accepted at edge 0; LOAD/XFER occupy NUM_LANES*(LANE_BITS+1) cycles (1625 at default); done asserted in the next cycle (cycle 1626 after acceptance). Each stall cycle adds exactly one cycle.
- Invariant: during XFER, dst_bit == (src_bit + offset[lane_idx]) mod LANE_BITS.

Decomposition:
- Shared encoder package: NUM_LANES, default LANE_BITS, the state enum (IDLE/LOAD/XFER/DONE), and the 25-entry rho offset constant array.
- One sub-module: rho_offset_rom. Input is lane (5 bits); output is offset mod LANE_BITS (combinational).
- The three counters and the FSM live in rho_rotate_ctrl.

Test Plan:
1. Reset, then start=1 for one cycle, no stall -> busy=1 next cycle; exactly 1600 xfer_en cycles; done pulses once at cycle 1626; busy=0 afterward.
2. Lane 2 -> first transfers are (src 0, dst 62), (1, 63), (2, 0) (wrap); last transfer is (63, 61); lane_idx then becomes 3 with a one-cycle xfer_en=0 gap (LOAD).
3. Lane 0 (offset 0) -> dst==src for all 64 cycles. Lane 24 -> first transfer (0, 14); after its transfer (63, 13) comes DONE.
4. stall=1 for 5 cycles at lane 7, src 10 -> xfer_en=0; outputs frozen at (7, 10, 16). Resume yields (7, 11, 17); done is delayed by exactly 5 cycles.
5. start pulsed during XFER and during DONE -> ignored; exactly one done; state IDLE afterward.
6. rst asserted at lane 12, src 30 -> all outputs 0 asynchronously, no done. A new start then yields a complete pass beginning at lane 0: (0, 0, 0).
